spectrum_filter_sequencer: RTL and testbench

Walks one FFT frame bin-by-bin after the FFT core finishes. Reads each complex bin from the spectrum RAM and applies a frame-latched cutoff mask (high-pass, low-pass, bypass or mute). Writes the result to the filtered-spectrum RAM that the IFFT consumes. Sits between the FFT output buffer and the IFFT input buffer, and is started once per frame by the audio frame controller.

---
 rtl/spectrum_pkg.sv | 27 ++
 rtl/bin_mask_stage.sv | 50 +++++
 rtl/spectrum_filter_sequencer.sv | 177 +++++++++++++++++
 tb/tb_spectrum_filter_sequencer.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/spectrum_pkg.sv
// spectrum_pkg: shared types and default sizes for the spectrum filter path
// (FFT output buffer -> filter sequencer -> IFFT input buffer).
`default_nettype none

package spectrum_pkg;

    localparam int DEF_N_BINS = 256;
    localparam int DEF_BIN_W  = 8;
    localparam int DEF_DATA_W = 16;

    typedef enum logic [1:0] {
        FILT_BYPASS = 2'd0,
        FILT_HPF    = 2'd1,
        FILT_LPF    = 2'd2,
        FILT_MUTE   = 2'd3
    } filt_mode_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } seq_state_t;

endpackage

`default_nettype wire

// File: rtl/bin_mask_stage.sv
// bin_mask_stage: combinational mirror-fold of a bin index and cutoff mask
// applied to one complex bin.
`default_nettype none

module bin_mask_stage
    import spectrum_pkg::*;
#(
    parameter int N_BINS = DEF_N_BINS,
    parameter int BIN_W  = DEF_BIN_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic [BIN_W-1:0]  k_i,
    input  logic [BIN_W-1:0]  cutoff_i,
    input  logic [1:0]        mode_i,
    input  logic [DATA_W-1:0] real_i,
    input  logic [DATA_W-1:0] imag_i,
    output logic [DATA_W-1:0] real_o,
    output logic [DATA_W-1:0] imag_o
);

    localparam logic [BIN_W:0] C_N    = (BIN_W+1)'(N_BINS);
    localparam logic [BIN_W:0] C_HALF = (BIN_W+1)'(N_BINS / 2);

    logic [BIN_W:0] w_k;
    logic [BIN_W:0] w_f;
    logic [BIN_W:0] w_cut;
    logic           w_zero;

    // Upper half of a real-signal spectrum mirrors the lower half.
    assign w_k   = {1'b0, k_i};
    assign w_f   = (w_k <= C_HALF) ? w_k : (C_N - w_k);
    assign w_cut = {1'b0, cutoff_i};

    always_comb begin
        w_zero = 1'b0;
        case (mode_i)
            FILT_BYPASS: w_zero = 1'b0;
            FILT_HPF:    w_zero = (w_f <= w_cut);
            FILT_LPF:    w_zero = (w_f > w_cut);
            FILT_MUTE:   w_zero = 1'b1;
            default:     w_zero = 1'b1;
        endcase
    end

    assign real_o = w_zero ? '0 : real_i;
    assign imag_o = w_zero ? '0 : imag_i;

endmodule

`default_nettype wire

// File: rtl/spectrum_filter_sequencer.sv
// spectrum_filter_sequencer: walks one FFT frame through read -> mask -> write
// with a stallable three-stage pipeline, once per START.
`default_nettype none

module spectrum_filter_sequencer
    import spectrum_pkg::*;
#(
    parameter int N_BINS = DEF_N_BINS,
    parameter int BIN_W  = DEF_BIN_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              start_i,
    input  logic [BIN_W-1:0]  cutoff_freq_i,
    input  logic [1:0]        mode_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              rd_en_o,
    output logic [BIN_W-1:0]  rd_addr_o,
    input  logic [DATA_W-1:0] rd_real_i,
    input  logic [DATA_W-1:0] rd_imag_i,
    output logic              wr_en_o,
    input  logic              wr_ready_i,
    output logic [BIN_W-1:0]  wr_addr_o,
    output logic [DATA_W-1:0] wr_real_o,
    output logic [DATA_W-1:0] wr_imag_o,
    output logic [15:0]       frame_count_o
);

    localparam logic [BIN_W-1:0] C_LAST = BIN_W'(N_BINS - 1);

    seq_state_t        state_q, state_d;
    logic [BIN_W-1:0]  cutoff_q, cutoff_d;
    logic [1:0]        mode_q, mode_d;
    logic [BIN_W-1:0]  rd_cnt_q, rd_cnt_d;
    logic              s1_valid_q, s1_valid_d;
    logic [BIN_W-1:0]  s1_k_q, s1_k_d;
    logic              wr_en_q, wr_en_d;
    logic [BIN_W-1:0]  wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0] wr_real_q, wr_real_d;
    logic [DATA_W-1:0] wr_imag_q, wr_imag_d;
    logic [15:0]       frame_count_q, frame_count_d;

    logic              w_stall;
    logic              w_wr_accept;
    logic              w_rd_en;
    logic              w_busy;
    logic              w_done;
    logic [DATA_W-1:0] w_mask_real;
    logic [DATA_W-1:0] w_mask_imag;

    assign w_stall     = wr_en_q & ~wr_ready_i;
    assign w_wr_accept = wr_en_q & wr_ready_i;

    // S1 data comes straight from the RAM, which holds its output while RD_EN is low.
    bin_mask_stage #(
        .N_BINS (N_BINS),
        .BIN_W  (BIN_W),
        .DATA_W (DATA_W)
    ) u_mask (
        .k_i      (s1_k_q),
        .cutoff_i (cutoff_q),
        .mode_i   (mode_q),
        .real_i   (rd_real_i),
        .imag_i   (rd_imag_i),
        .real_o   (w_mask_real),
        .imag_o   (w_mask_imag)
    );

    always_comb begin
        state_d       = state_q;
        cutoff_d      = cutoff_q;
        mode_d        = mode_q;
        rd_cnt_d      = rd_cnt_q;
        frame_count_d = frame_count_q;
        s1_valid_d    = s1_valid_q;
        s1_k_d        = s1_k_q;
        w_rd_en       = 1'b0;
        w_busy        = 1'b0;
        w_done        = 1'b0;

        if (!w_stall) begin
            s1_valid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d  = RUN;
                    cutoff_d = cutoff_freq_i;
                    mode_d   = mode_i;
                    rd_cnt_d = '0;
                end
            end
            RUN: begin
                w_busy = 1'b1;
                if (!w_stall) begin
                    w_rd_en    = 1'b1;
                    s1_valid_d = 1'b1;
                    s1_k_d     = rd_cnt_q;
                    if (rd_cnt_q == C_LAST) begin
                        state_d = DRAIN;
                    end else begin
                        rd_cnt_d = rd_cnt_q + BIN_W'(1);
                    end
                end
            end
            DRAIN: begin
                w_busy = 1'b1;
                if (w_wr_accept && (wr_addr_q == C_LAST)) begin
                    state_d       = DONE;
                    frame_count_d = frame_count_q + 16'd1;
                end
            end
            DONE: begin
                w_done  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        wr_en_d   = wr_en_q;
        wr_addr_d = wr_addr_q;
        wr_real_d = wr_real_q;
        wr_imag_d = wr_imag_q;
        if (!w_stall) begin
            wr_en_d   = s1_valid_q;
            wr_addr_d = s1_k_q;
            wr_real_d = s1_valid_q ? w_mask_real : '0;
            wr_imag_d = s1_valid_q ? w_mask_imag : '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= IDLE;
            cutoff_q      <= '0;
            mode_q        <= '0;
            rd_cnt_q      <= '0;
            s1_valid_q    <= 1'b0;
            s1_k_q        <= '0;
            wr_en_q       <= 1'b0;
            wr_addr_q     <= '0;
            wr_real_q     <= '0;
            wr_imag_q     <= '0;
            frame_count_q <= '0;
        end else begin
            state_q       <= state_d;
            cutoff_q      <= cutoff_d;
            mode_q        <= mode_d;
            rd_cnt_q      <= rd_cnt_d;
            s1_valid_q    <= s1_valid_d;
            s1_k_q        <= s1_k_d;
            wr_en_q       <= wr_en_d;
            wr_addr_q     <= wr_addr_d;
            wr_real_q     <= wr_real_d;
            wr_imag_q     <= wr_imag_d;
            frame_count_q <= frame_count_d;
        end
    end

    assign busy_o        = w_busy;
    assign done_o        = w_done;
    assign rd_en_o       = w_rd_en;
    assign rd_addr_o     = rd_cnt_q;
    assign wr_en_o       = wr_en_q;
    assign wr_addr_o     = wr_addr_q;
    assign wr_real_o     = wr_real_q;
    assign wr_imag_o     = wr_imag_q;
    assign frame_count_o = frame_count_q;

endmodule

`default_nettype wire

// File: tb/tb_spectrum_filter_sequencer.sv
// tb_spectrum_filter_sequencer: randomized frames checked against a bin-level
// reference model of the fold/mask rules and frame timing.
`default_nettype none

module tb_spectrum_filter_sequencer;

    localparam int N = 256;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start_i;
    logic [7:0]  cutoff_freq_i;
    logic [1:0]  mode_i;
    logic        busy_o, done_o, rd_en_o, wr_en_o, wr_ready_i;
    logic [7:0]  rd_addr_o, wr_addr_o;
    logic [15:0] rd_real_i, rd_imag_i, wr_real_o, wr_imag_o, frame_count_o;

    logic [15:0] mem_re [N];
    logic [15:0] mem_im [N];

    int errors = 0;
    int checks = 0;
    int exp_fc = 0;

    spectrum_filter_sequencer dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .start_i       (start_i),
        .cutoff_freq_i (cutoff_freq_i),
        .mode_i        (mode_i),
        .busy_o        (busy_o),
        .done_o        (done_o),
        .rd_en_o       (rd_en_o),
        .rd_addr_o     (rd_addr_o),
        .rd_real_i     (rd_real_i),
        .rd_imag_i     (rd_imag_i),
        .wr_en_o       (wr_en_o),
        .wr_ready_i    (wr_ready_i),
        .wr_addr_o     (wr_addr_o),
        .wr_real_o     (wr_real_o),
        .wr_imag_o     (wr_imag_o),
        .frame_count_o (frame_count_o)
    );

    always #5 clk = ~clk;

    // Synchronous-read spectrum RAM: output holds while RD_EN is low.
    always @(posedge clk) begin
        if (rd_en_o) begin
            rd_real_i <= mem_re[rd_addr_o];
            rd_imag_i <= mem_im[rd_addr_o];
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic bit is_zeroed(input int k, input int mode, input int cut);
        int f;
        f = (k <= N / 2) ? k : N - k;
        case (mode)
            0:       return 1'b0;
            1:       return f <= cut;
            2:       return f > cut;
            default: return 1'b1;
        endcase
    endfunction

    task automatic check_all_zero();
        check_eq("rst_busy",   32'(busy_o), 0);
        check_eq("rst_done",   32'(done_o), 0);
        check_eq("rst_rd_en",  32'(rd_en_o), 0);
        check_eq("rst_rdaddr", 32'(rd_addr_o), 0);
        check_eq("rst_wr_en",  32'(wr_en_o), 0);
        check_eq("rst_wraddr", 32'(wr_addr_o), 0);
        check_eq("rst_wrre",   32'(wr_real_o), 0);
        check_eq("rst_wrim",   32'(wr_imag_o), 0);
        check_eq("rst_fc",     32'(frame_count_o), 0);
    endtask

    // stall_kind: 0 = always ready, 1 = 5-cycle stall on bin 40, 2 = random stalls
    task automatic run_frame(input int mode, input int cut, input bit ramp,
                             input int stall_kind, input bit restart, input int reset_bin);
        int cyc, idx, first_wr, done_cyc, stalls, hold, done_seen;
        bit stalled40;
        logic [7:0] stall_rd_addr;
        logic [15:0] ere, eim;
        for (int k = 0; k < N; k++) begin
            mem_re[k] = ramp ? 16'(k) : (16'($urandom) | 16'd1);
            mem_im[k] = ramp ? 16'(0 - k) : (16'($urandom) | 16'd1);
        end
        @(negedge clk);
        start_i = 1'b1; cutoff_freq_i = 8'(cut); mode_i = 2'(mode); wr_ready_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        cyc = 0; idx = 0; first_wr = -1; done_cyc = -1; stalls = 0; hold = 0;
        stalled40 = 1'b0; stall_rd_addr = '0;
        while (1) begin
            if (cyc > 2000) begin
                check_eq("timeout", 1, 0);
                break;
            end
            start_i = 1'b0;
            if (restart && cyc == 60) begin
                start_i = 1'b1; cutoff_freq_i = 8'd0; mode_i = (mode == 3) ? 2'd0 : 2'd3;
            end
            case (stall_kind)
                1: begin
                    if (hold > 0) begin
                        wr_ready_i = 1'b0; hold--;
                    end else if (!stalled40 && wr_en_o && wr_addr_o == 8'd40) begin
                        wr_ready_i = 1'b0; hold = 4; stalled40 = 1'b1; stall_rd_addr = rd_addr_o;
                    end else begin
                        wr_ready_i = 1'b1;
                    end
                end
                2:       wr_ready_i = ($urandom_range(0, 3) != 0);
                default: wr_ready_i = 1'b1;
            endcase
            if (reset_bin >= 0 && wr_en_o && wr_addr_o == 8'(reset_bin)) begin
                rst_n = 1'b0;
                #1;
                check_all_zero();
                exp_fc = 0;
                @(negedge clk);
                rst_n = 1'b1;
                start_i = 1'b0;
                done_seen = 0;
                for (int i = 0; i < 300; i++) begin
                    @(negedge clk);
                    if (done_o) done_seen++;
                end
                check_eq("no_done_after_rst", 32'(done_seen), 0);
                return;
            end
            #1;
            if (wr_en_o && !wr_ready_i) stalls++;
            if (stall_kind == 1 && !wr_ready_i) begin
                ere = is_zeroed(40, mode, cut) ? 16'd0 : mem_re[40];
                check_eq("stall_rd_en",  32'(rd_en_o), 0);
                check_eq("stall_rdaddr", 32'(rd_addr_o), 32'(stall_rd_addr));
                check_eq("stall_wraddr", 32'(wr_addr_o), 40);
                check_eq("stall_wrre",   32'(wr_real_o), 32'(ere));
            end
            if (restart && cyc == 61) check_eq("restart_busy", 32'(busy_o), 1);
            if (done_o) begin
                done_cyc = cyc;
                exp_fc++;
                check_eq("done_busy", 32'(busy_o), 0);
                check_eq("frame_count", 32'(frame_count_o), 32'(exp_fc));
                break;
            end
            if (wr_en_o && first_wr < 0) first_wr = cyc;
            if (wr_en_o && wr_ready_i) begin
                ere = is_zeroed(idx, mode, cut) ? 16'd0 : mem_re[idx];
                eim = is_zeroed(idx, mode, cut) ? 16'd0 : mem_im[idx];
                check_eq("wr_addr", 32'(wr_addr_o), 32'(idx));
                check_eq("wr_real", 32'(wr_real_o), 32'(ere));
                check_eq("wr_imag", 32'(wr_imag_o), 32'(eim));
                idx++;
            end
            @(negedge clk);
            cyc++;
        end
        check_eq("n_writes", 32'(idx), N);
        check_eq("first_wr_cyc", 32'(first_wr), 2);
        check_eq("done_cyc", 32'(done_cyc), 32'(258 + stalls));
        if (stall_kind == 1) check_eq("stall_cycles", 32'(stalls), 5);
        @(negedge clk);
        #1;
        check_eq("done_pulse", 32'(done_o), 0);
        check_eq("idle_busy", 32'(busy_o), 0);
    endtask

    initial begin
        rst_n = 1'b0; start_i = 1'b0; cutoff_freq_i = '0; mode_i = '0; wr_ready_i = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check_all_zero();
        rst_n = 1'b1;
        @(negedge clk);

        run_frame(0, 0,   1'b1, 0, 1'b0, -1);   // bypass ramp, no stalls
        run_frame(1, 10,  1'b0, 0, 1'b0, -1);   // high-pass at 10
        run_frame(2, 128, 1'b0, 0, 1'b0, -1);   // low-pass passes all
        run_frame(2, 0,   1'b0, 0, 1'b0, -1);   // low-pass keeps bin 0 only
        run_frame(0, 0,   1'b1, 1, 1'b0, -1);   // stall on bin 40
        run_frame(1, 50,  1'b0, 0, 1'b1, -1);   // ignored mid-frame START
        run_frame(3, 7,   1'b0, 2, 1'b0, -1);   // mute with random stalls
        for (int i = 0; i < 3; i++) begin
            run_frame(int'($urandom_range(0, 3)), int'($urandom_range(0, 255)), 1'b0, 2, 1'b0, -1);
        end
        run_frame(1, 20,  1'b0, 0, 1'b0, 100);  // reset mid-frame
        run_frame(int'($urandom_range(0, 3)), int'($urandom_range(0, 255)), 1'b0, 2, 1'b0, -1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
